// File: rtl/q_measure.sv
// Two-qubit measurement stage: squares the four amplitudes on one shared
// squarer, accumulates the CDF and picks a basis state against an LFSR threshold.
module q_measure #(
  parameter int W    = 32,
  parameter int FRAC = 16,
  parameter int TOL  = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic signed [W-1:0] in_real_00,
  input  logic signed [W-1:0] in_imag_00,
  input  logic signed [W-1:0] in_real_01,
  input  logic signed [W-1:0] in_imag_01,
  input  logic signed [W-1:0] in_real_10,
  input  logic signed [W-1:0] in_imag_10,
  input  logic signed [W-1:0] in_real_11,
  input  logic signed [W-1:0] in_imag_11,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [15:0]         seed,
  input  logic                seed_load,
  output logic [W-1:0]        out_prob_00,
  output logic [W-1:0]        out_prob_01,
  output logic [W-1:0]        out_prob_10,
  output logic [W-1:0]        out_prob_11,
  output logic [1:0]          out_state,
  output logic                out_norm_err,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [1:0]          o_dbg_state,
  output logic [15:0]         o_dbg_lfsr
);

  // Handshakes: a transfer happens on a rising edge where valid && ready;
  // valid never depends on ready, and a raised out_valid holds its data until taken.
  typedef enum logic [1:0] {S_IDLE, S_CALC, S_SELECT, S_DONE} state_t;

  state_t              r_state;
  state_t              w_next;
  logic [1:0]          r_k;
  logic signed [W-1:0] r_re [4];
  logic signed [W-1:0] r_im [4];
  logic [W-1:0]        r_p [4];
  logic [W+1:0]        r_cum [4];
  logic [W-1:0]        r_prob [4];
  logic [1:0]          r_sel;
  logic                r_norm_err;
  logic [15:0]         r_lfsr;
  logic [FRAC-1:0]     r_thresh;

  logic                  w_accept;
  logic [15:0]           w_lfsr_step;
  logic signed [2*W-1:0] w_re_ext, w_im_ext, w_sq_re, w_sq_im;
  logic [2*W-1:0]        w_sq_sum, w_shift;
  logic [W-1:0]          w_p;
  logic [W+1:0]          w_cum_prev, w_cum_new, w_thr, w_one, w_dev;
  logic                  w_norm_err;
  logic [1:0]            w_sel;

  assign w_accept    = in_valid && (r_state == S_IDLE);
  assign w_lfsr_step = {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);

  // Shared squarer; both squares are non-negative so the sum fits 2W unsigned bits.
  assign w_re_ext = $signed({{W{r_re[r_k][W-1]}}, r_re[r_k]});
  assign w_im_ext = $signed({{W{r_im[r_k][W-1]}}, r_im[r_k]});
  assign w_sq_re  = w_re_ext * w_re_ext;
  assign w_sq_im  = w_im_ext * w_im_ext;
  assign w_sq_sum = $unsigned(w_sq_re) + $unsigned(w_sq_im);
  assign w_shift  = w_sq_sum >> FRAC;
  assign w_p      = (|w_shift[2*W-1:W-1]) ? {1'b0, {(W-1){1'b1}}} : w_shift[W-1:0];

  assign w_cum_prev = (r_k == 2'd0) ? '0 : r_cum[r_k - 2'd1];
  assign w_cum_new  = w_cum_prev + {2'b00, w_p};

  assign w_thr      = {{(W+2-FRAC){1'b0}}, r_thresh};
  assign w_one      = (W+2)'(1) << FRAC;
  assign w_dev      = (r_cum[3] >= w_one) ? (r_cum[3] - w_one) : (w_one - r_cum[3]);
  assign w_norm_err = (w_dev > (W+2)'(TOL));

  always_comb begin
    w_sel = 2'b11;
    for (int k = 3; k >= 0; k--) begin
      if (r_cum[k] > w_thr) w_sel = k[1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_accept) w_next = S_CALC;
      S_CALC:   if (r_k == 2'd3) w_next = S_SELECT;
      S_SELECT: w_next = S_DONE;
      S_DONE:   if (out_ready) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_k        <= 2'd0;
      r_lfsr     <= 16'hACE1;
      r_thresh   <= '0;
      r_sel      <= 2'b00;
      r_norm_err <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        r_re[i]   <= '0;
        r_im[i]   <= '0;
        r_p[i]    <= '0;
        r_cum[i]  <= '0;
        r_prob[i] <= '0;
      end
    end else begin
      if (r_state == S_IDLE) begin
        // A simultaneous seed load wins the LFSR, but the threshold still
        // comes from the value that was there before the edge.
        if (seed_load)     r_lfsr <= (seed == 16'h0000) ? 16'hACE1 : seed;
        else if (w_accept) r_lfsr <= w_lfsr_step;
        if (w_accept) begin
          r_thresh <= r_lfsr[15 -: FRAC];
          r_k      <= 2'd0;
          r_re[0]  <= in_real_00;  r_im[0] <= in_imag_00;
          r_re[1]  <= in_real_01;  r_im[1] <= in_imag_01;
          r_re[2]  <= in_real_10;  r_im[2] <= in_imag_10;
          r_re[3]  <= in_real_11;  r_im[3] <= in_imag_11;
        end
      end
      if (r_state == S_CALC) begin
        r_p[r_k]   <= w_p;
        r_cum[r_k] <= w_cum_new;
        r_k        <= r_k + 2'd1;
      end
      if (r_state == S_SELECT) begin
        for (int i = 0; i < 4; i++) r_prob[i] <= r_p[i];
        r_sel      <= w_sel;
        r_norm_err <= w_norm_err;
      end
    end
  end

  assign in_ready     = (r_state == S_IDLE);
  assign out_valid    = (r_state == S_DONE);
  assign out_prob_00  = r_prob[0];
  assign out_prob_01  = r_prob[1];
  assign out_prob_10  = r_prob[2];
  assign out_prob_11  = r_prob[3];
  assign out_state    = r_sel;
  assign out_norm_err = r_norm_err;
  assign o_dbg_state  = r_state;
  assign o_dbg_lfsr   = r_lfsr;

endmodule

// File: doc/q_measure.md
Q_MEASURE -- requirements
Module: q_measure

Interface
REQ-001 Parameter W, default 32: signed fixed-point amplitude/probability width.
REQ-002 Parameter FRAC, default 16, legal range 8..16: fraction bits; 1.0 = 1<<FRAC.
REQ-003 Parameter TOL, default 4: normalisation tolerance in LSBs.
REQ-004 Port clk  in  1: sole clock; all state on rising edge.
REQ-005 Port rst_n  in  1: reset, asynchronous, active-low.
REQ-006 Ports in_real_00, in_imag_00, in_real_01, in_imag_01, in_real_10, in_imag_10, in_real_11, in_imag_11  in  W each: signed two-qubit amplitudes from the CNOT stage.
REQ-007 Port in_valid  in  1: amplitude set valid.
REQ-008 Port in_ready  out  1: block can accept a set.
REQ-009 Port seed  in  16: LFSR seed value.
REQ-010 Port seed_load  in  1: load seed; honoured only in IDLE.
REQ-011 Ports out_prob_00, out_prob_01, out_prob_10, out_prob_11  out  W each: |amplitude|^2, same fixed-point format.
REQ-012 Port out_state  out  2: measured basis index, {control, target}.
REQ-013 Port out_norm_err  out  1: probability sum outside 1.0 +/- TOL.
REQ-014 Port out_valid  out  1: result valid. Port out_ready  in  1: consumer accepts result.

Function
REQ-015 FSM states IDLE, CALC, SELECT, DONE; IDLE->CALC on in_valid&&in_ready; CALC->SELECT after 4 cycles; SELECT->DONE after 1 cycle; DONE->IDLE on out_valid&&out_ready.
REQ-016 in_ready = 1 only in IDLE; all 8 amplitudes are registered at the accept edge; later input changes are ignored.
REQ-017 At the accept edge, threshold register captures lfsr[15 -: FRAC] (pre-advance value), and the LFSR then advances one step.
REQ-018 LFSR: 16-bit Galois, mask 0xB400, shifts right; advances only on accept edges.
REQ-019 seed_load in IDLE loads seed at next edge; seed 0x0000 loads 0xACE1 instead; seed_load together with accept: seed loaded, threshold taken from the pre-load LFSR value.
REQ-020 CALC uses one shared squarer path, index k = 0,1,2,3 on successive cycles: p_k = (re*re + im*im) >>> FRAC, full 2W-bit products, truncation, saturate to 2^(W-1)-1.
REQ-021 CALC keeps a running cumulative sum cum_k (W+2 bits, unsigned) per index.
REQ-022 SELECT: out_state = smallest k with cum_k > threshold; if none, out_state = 2'b11.
REQ-023 SELECT: out_norm_err = 1 iff |cum_3 - (1<<FRAC)| > TOL.
REQ-024 out_valid asserted in DONE only, first asserted 6 edges after accept (4 CALC + 1 SELECT + entry); held, with all outputs stable, until out_ready.
REQ-025 out_prob_*, out_state, out_norm_err retain the last result after DONE until overwritten by the next SELECT.
REQ-026 Back-to-back: in_ready rises the cycle after the out_valid&&out_ready handshake; minimum initiation interval 7 cycles.

Reset
REQ-027 rst_n low, at any time including mid-CALC or DONE: state IDLE, in_ready 1 after release, out_valid 0, out_prob_* 0, out_state 0, out_norm_err 0, threshold 0, LFSR 0xACE1.
REQ-028 Transaction in flight at reset is discarded; no partial result is ever presented.

Verification (W=32, FRAC=16)
REQ-029 Input |10> (in_real_10=0x00010000, others 0), out_ready=1 -> out_prob_10=0x00010000, others 0, out_state=2'b10, out_norm_err=0, out_valid 6 cycles after accept.
REQ-030 Bell input in_real_00=in_real_11=0x0000B505, others 0, seed 0x1000 -> out_prob_00=out_prob_11=0x00008000, out_state=2'b00; repeat with seed 0x9000 -> out_state=2'b11.
REQ-031 All-zero input -> all probs 0, out_state=2'b11, out_norm_err=1.
REQ-032 out_ready held low 10 cycles in DONE -> out_valid and outputs stable, in_ready 0 throughout, new in_valid ignored.
REQ-033 rst_n pulsed low during CALC cycle 2 -> out_valid never asserts for that set; LFSR reads 0xACE1; next transaction completes normally.
REQ-034 seed_load with seed 0x0000, then 1000 accepts -> LFSR never 0x0000; sequence matches reference model from 0xACE1.
